// File: rtl/vr_stream_source_if.sv
// Stream-source handshake bundle: burst request in, valid/ready data stream out.
// With VR_SRC_STALL_CNT_EN defined the bundle also carries the 16-bit stall_cnt.
interface vr_stream_source_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] seed;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic              ready_out;
  logic              last_out;
  logic              busy;
  logic              done;
`ifdef VR_SRC_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  modport master (
    input  start, len, seed, ready_out,
`ifdef VR_SRC_STALL_CNT_EN
    output stall_cnt,
`endif
    output valid_out, data_out, last_out, busy, done
  );

  modport slave (
    output start, len, seed, ready_out,
`ifdef VR_SRC_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  valid_out, data_out, last_out, busy, done
  );
endinterface

// File: rtl/vr_stream_source.sv
// Burst stream source: emits len incrementing words starting at seed under valid/ready.
// Optional VR_SRC_STALL_CNT_EN adds a saturating count of backpressured cycles.
module vr_stream_source #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input logic                clk,
  input logic                rst,
  vr_stream_source_if.master bus_io
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e            state_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic [LEN_W-1:0]  remain_q;  // beats left, including the one on data_q

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      remain_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus_io.start) begin
            busy_q <= 1'b1;
            if (bus_io.len != '0) begin
              state_q  <= StSend;
              valid_q  <= 1'b1;
              data_q   <= bus_io.seed;
              remain_q <= bus_io.len;
              last_q   <= (bus_io.len == LEN_W'(1));
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StSend: begin
          if (bus_io.ready_out) begin
            data_q   <= data_q + DATA_W'(1);
            remain_q <= remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              last_q <= (remain_q == LEN_W'(2));
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.valid_out = valid_q;
  assign bus_io.data_out  = data_q;
  assign bus_io.last_out  = last_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;

`ifdef VR_SRC_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == StIdle && bus_io.start) begin
      stall_d = '0;
    end else if (valid_q && !bus_io.ready_out && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus_io.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_vr_stream_source.sv
// Self-checking bench for vr_stream_source: directed vector table, corner sequences,
// and random traffic scored against a queue-based model of the expected word stream.
module tb_vr_stream_source;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vr_stream_source_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

  vr_stream_source #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: words still owed to downstream, a pending done pulse, and the stall count.
  logic [7:0]  mq[$];
  bit          m_done = 1'b0;
  int unsigned m_stall = 0;

  logic [7:0]  got[$];
  int          n_done = 0;

  typedef struct {
    bit         r;
    bit         s;
    logic [7:0] l;
    logic [7:0] sd;
    bit         rd;
    bit         v;
    logic [7:0] d;
    bit         cd;
    bit         last;
    bit         b;
    bit         dn;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input logic [7:0] l,
                            input logic [7:0] sd, input bit rd);
    if (r) begin
      mq.delete();
      m_done  = 1'b0;
      m_stall = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (mq.size() != 0) begin
      if (rd) begin
        mq.delete(0);
        if (mq.size() == 0) m_done = 1'b1;
      end else if (m_stall < 32'hFFFF) begin
        m_stall++;
      end
    end else if (s) begin
      m_stall = 0;
      for (int i = 0; i < int'(l); i++) mq.push_back(sd + 8'(i));
      if (l == 8'd0) m_done = 1'b1;
    end
  endtask

  task automatic cycle(input bit r, input bit s, input logic [7:0] l,
                       input logic [7:0] sd, input bit rd);
    rst           = r;
    bus.start     = s;
    bus.len       = l;
    bus.seed      = sd;
    bus.ready_out = rd;
    if (!r && bus.valid_out === 1'b1 && rd) got.push_back(bus.data_out);
    model_step(r, s, l, sd, rd);
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) n_done++;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(bus.valid_out), 32'(mq.size() != 0));
    chk({tag, ".last"},  32'(bus.last_out),  32'(mq.size() == 1));
    chk({tag, ".busy"},  32'(bus.busy),      32'(mq.size() != 0 || m_done));
    chk({tag, ".done"},  32'(bus.done),      32'(m_done));
    if (mq.size() != 0) chk({tag, ".data"}, 32'(bus.data_out), 32'(mq[0]));
`ifdef VR_SRC_STALL_CNT_EN
    chk({tag, ".stall"}, 32'(bus.stall_cnt), m_stall);
`endif
  endtask

  task automatic add(input bit r, input bit s, input logic [7:0] l, input logic [7:0] sd,
                     input bit rd, input bit v, input logic [7:0] d, input bit cd,
                     input bit last, input bit b, input bit dn);
    vec_t t;
    t.r = r; t.s = s; t.l = l; t.sd = sd; t.rd = rd;
    t.v = v; t.d = d; t.cd = cd; t.last = last; t.b = b; t.dn = dn;
    tbl.push_back(t);
  endtask

  initial begin
    bit pat[5];
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.seed      = '0;
    bus.ready_out = 1'b1;

    //   r  s  len    seed   rdy  v  data   cd last busy done
    add(1, 0, 8'd0, 8'h00, 1,   0, 8'h00, 1, 0,   0,   0);  // reset values
    add(0, 1, 8'd4, 8'h10, 1,   1, 8'h10, 1, 0,   1,   0);  // 4-beat burst, no stalls
    add(0, 0, 8'd0, 8'h00, 1,   1, 8'h11, 1, 0,   1,   0);
    add(0, 0, 8'd0, 8'h00, 1,   1, 8'h12, 1, 0,   1,   0);
    add(0, 0, 8'd0, 8'h00, 1,   1, 8'h13, 1, 1,   1,   0);
    add(0, 0, 8'd0, 8'h00, 1,   0, 8'h00, 0, 0,   1,   1);
    add(0, 0, 8'd0, 8'h00, 1,   0, 8'h00, 0, 0,   0,   0);
    add(0, 1, 8'd3, 8'hFE, 1,   1, 8'hFE, 1, 0,   1,   0);  // data wraps past 0xFF
    add(0, 0, 8'd0, 8'h00, 1,   1, 8'hFF, 1, 0,   1,   0);
    add(0, 0, 8'd0, 8'h00, 1,   1, 8'h00, 1, 1,   1,   0);
    add(0, 0, 8'd0, 8'h00, 1,   0, 8'h00, 0, 0,   1,   1);
    add(0, 0, 8'd0, 8'h00, 1,   0, 8'h00, 0, 0,   0,   0);
    add(0, 1, 8'd0, 8'h33, 1,   0, 8'h00, 0, 0,   1,   1);  // len=0: straight to done
    add(0, 0, 8'd0, 8'h00, 1,   0, 8'h00, 0, 0,   0,   0);
    add(0, 1, 8'd1, 8'h55, 0,   1, 8'h55, 1, 1,   1,   0);  // single beat, held under stall
    add(0, 0, 8'd0, 8'h00, 0,   1, 8'h55, 1, 1,   1,   0);
    add(0, 0, 8'd0, 8'h00, 1,   0, 8'h00, 0, 0,   1,   1);
    add(0, 0, 8'd0, 8'h00, 1,   0, 8'h00, 0, 0,   0,   0);

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].sd, tbl[i].rd);
      check_model("tbl_model");
      chk($sformatf("tbl%0d.valid", i), 32'(bus.valid_out), 32'(tbl[i].v));
      chk($sformatf("tbl%0d.last", i),  32'(bus.last_out),  32'(tbl[i].last));
      chk($sformatf("tbl%0d.busy", i),  32'(bus.busy),      32'(tbl[i].b));
      chk($sformatf("tbl%0d.done", i),  32'(bus.done),      32'(tbl[i].dn));
      if (tbl[i].cd) chk($sformatf("tbl%0d.data", i), 32'(bus.data_out), 32'(tbl[i].d));
    end

    // Backpressure pattern 0,1,0,1,1 on a 3-beat burst.
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    got.delete();
    cycle(0, 1, 8'd3, 8'h20, 1'b0);
    check_model("bp");
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 8'd0, 8'h00, pat[k]);
      check_model("bp");
    end
    chk("bp.beats", 32'(got.size()), 32'd3);
    for (int i = 0; i < got.size() && i < 3; i++)
      chk($sformatf("bp.word%0d", i), 32'(got[i]), 32'(8'h20 + 8'(i)));
`ifdef VR_SRC_STALL_CNT_EN
    chk("bp.stall_cnt", 32'(bus.stall_cnt), 32'd2);
`endif
    cycle(0, 0, 8'd0, 8'h00, 1'b1);
    check_model("bp");

    // Reset after the second transfer of a 5-beat burst abandons it.
    got.delete();
    cycle(0, 1, 8'd5, 8'h30, 1'b1);
    cycle(0, 0, 8'd0, 8'h00, 1'b1);
    cycle(0, 0, 8'd0, 8'h00, 1'b1);
    n_done = 0;
    cycle(1, 0, 8'd0, 8'h00, 1'b1);
    chk("rst_mid.valid", 32'(bus.valid_out), 32'd0);
    chk("rst_mid.busy",  32'(bus.busy),      32'd0);
    chk("rst_mid.data",  32'(bus.data_out),  32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 8'd0, 8'h00, 1'b1);
      check_model("rst_mid");
    end
    chk("rst_mid.beats", 32'(got.size()), 32'd2);
    chk("rst_mid.no_done", 32'(n_done), 32'd0);

    // Start requests during SEND and DONE are ignored.
    got.delete();
    n_done = 0;
    cycle(0, 1, 8'd4, 8'h40, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 8'd2, 8'h77, 1'b1);
      check_model("ign");
    end
    cycle(0, 0, 8'd0, 8'h00, 1'b1);
    cycle(0, 0, 8'd0, 8'h00, 1'b1);
    chk("ign.beats", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("ign.word%0d", i), 32'(got[i]), 32'(8'h40 + 8'(i)));
    chk("ign.done_cnt", 32'(n_done), 32'd1);

    // Reset wins over a simultaneous start.
    cycle(1, 1, 8'd3, 8'h50, 1'b1);
    chk("rst_start.valid", 32'(bus.valid_out), 32'd0);
    chk("rst_start.busy",  32'(bus.busy),      32'd0);
    cycle(0, 0, 8'd0, 8'h00, 1'b1);
    chk("rst_start.valid2", 32'(bus.valid_out), 32'd0);
    chk("rst_start.busy2",  32'(bus.busy),      32'd0);

    for (int n = 0; n < 3000; n++) begin
      bit         r, s, rd;
      logic [7:0] l, sd;
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 5) == 0);
      l  = 8'($urandom_range(0, 6));
      sd = 8'($urandom);
      rd = ($urandom_range(0, 9) < 7);
      cycle(r, s, l, sd, rd);
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vr_stream_source.md
VR_STREAM_SOURCE -- requirements
Module: vr_stream_source

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data word width in bits.
REQ-002 Parameter LEN_W, default 8, SHALL set the burst-length field width in bits.
REQ-003 clk  in  1  SHALL be the single clock; all logic is on the rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 start  in  1  SHALL be a single-cycle burst request.
REQ-006 len  in  LEN_W  SHALL give the number of words in the burst, sampled with start.
REQ-007 seed  in  DATA_W  SHALL give the first data word, sampled with start.
REQ-008 valid_out  out  1  SHALL mark data_out as valid toward the downstream stage.
REQ-009 data_out  out  DATA_W  SHALL carry the current stream word.
REQ-010 ready_out  in  1  SHALL be the downstream ready (backpressure) input.
REQ-011 last_out  out  1  SHALL mark the final beat of a burst.
REQ-012 busy  out  1  SHALL be high while a burst is in progress.
REQ-013 done  out  1  SHALL pulse high for one cycle when a burst completes.

Function
REQ-014 The FSM SHALL have three states, IDLE, SEND and DONE, and SHALL reset to IDLE.
REQ-015 IDLE, start=1, len!=0: latch len and seed, go to SEND; valid_out=1 with data_out=seed on the next cycle.
REQ-016 IDLE, start=1, len=0: go to DONE directly; valid_out SHALL never assert for that burst.
REQ-017 A beat SHALL transfer on a cycle with valid_out=1 and ready_out=1; peak throughput is one beat per cycle.
REQ-018 valid_out=1 and ready_out=0: valid_out, data_out and last_out SHALL hold stable until the transfer.
REQ-019 After each transfer, data_out SHALL increment by 1 modulo 2^DATA_W (0xFF -> 0x00 at DATA_W=8), and the remaining count SHALL decrement.
REQ-020 last_out SHALL be high exactly while valid_out=1 and one beat remains; it is 0 at all other times.
REQ-021 On the final transfer, the FSM SHALL enter DONE with valid_out=0 on the next cycle.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-023 busy SHALL be 1 in SEND and DONE and 0 in IDLE.
REQ-024 start in SEND or DONE SHALL be ignored, with no effect on the current burst.
REQ-025 In IDLE, start and done may coincide: a start on the cycle after done SHALL be accepted.
REQ-026 valid_out SHALL not depend combinationally on ready_out.

Reset
REQ-027 On rst=1 at a clock edge, outputs SHALL take these values on the next cycle: valid_out=0, last_out=0, busy=0, done=0, data_out=0; FSM in IDLE.
REQ-028 rst mid-burst SHALL abandon the burst: no further beats and no done pulse.
REQ-029 rst SHALL take priority over start on the same edge.

Configuration
REQ-030 With macro VR_SRC_STALL_CNT_EN defined, the block SHALL have an extra output stall_cnt (out, 16 bits).
REQ-031 stall_cnt SHALL count cycles with valid_out=1 and ready_out=0, saturate at 0xFFFF, and clear on an accepted start and on rst.
REQ-032 Without VR_SRC_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 len=4, seed=0x10, ready_out held 1 -> data_out 0x10,0x11,0x12,0x13 on 4 consecutive cycles; last_out on 0x13; done the next cycle.
REQ-034 len=3, seed=0x20, ready_out pattern 0,1,0,1,1 -> each word held until accepted; no word dropped or duplicated; stall_cnt=2 (macro on).
REQ-035 len=3, seed=0xFE -> data_out 0xFE, 0xFF, 0x00; last_out on 0x00.
REQ-036 len=0 start -> done pulse the cycle after start; valid_out stays 0.
REQ-037 rst asserted after the 2nd transfer of a len=5 burst -> valid_out=0 and busy=0 next cycle; no done.
REQ-038 start with len=2 issued mid-burst of len=4 -> ignored; exactly 4 beats, then one done.
